// File: rtl/immgen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : immgen_pipe
// Description : Pipelined RISC-V immediate generator for the decode stage.
//               Classifies the opcode, builds the XLEN-wide immediate, and
//               computes the PC-relative target. It then carries the result
//               through DEPTH valid/ready register stages, with flush support.
// Ports       : i_clk, i_reset    - clock (rising edge), async active-high reset
//               i_valid, o_ready  - input beat handshake (o_ready combinational)
//               i_instr, i_pc     - instruction word and its address
//               i_flush           - drop every in-flight beat on the next edge
//               o_valid, i_ready  - output beat handshake
//               o_imm, o_imm_type - immediate and its class (0 NONE..6 SHAMT)
//               o_pc, o_target    - PC passthrough and pc + imm (mod 2^XLEN)
// Revision    : 1.0 - initial release
// ============================================================================
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_target
);

  localparam logic [2:0] TYPE_NONE  = 3'd0;
  localparam logic [2:0] TYPE_I     = 3'd1;
  localparam logic [2:0] TYPE_S     = 3'd2;
  localparam logic [2:0] TYPE_B     = 3'd3;
  localparam logic [2:0] TYPE_U     = 3'd4;
  localparam logic [2:0] TYPE_J     = 3'd5;
  localparam logic [2:0] TYPE_SHAMT = 3'd6;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [2:0]      dec_type;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;

  assign opcode   = i_instr[6:0];
  assign funct3   = i_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Opcode classification
  always_comb begin
    dec_type = TYPE_NONE;
    case (opcode)
      OPC_LOAD, OPC_JALR: dec_type = TYPE_I;
      OPC_OP_IMM:         dec_type = is_shift ? TYPE_SHAMT : TYPE_I;
      OPC_OP_IMM32: begin
        // The word-sized shift/add forms only exist on RV64.
        if (XLEN == 64) begin
          dec_type = is_shift ? TYPE_SHAMT : TYPE_I;
        end
      end
      OPC_STORE:          dec_type = TYPE_S;
      OPC_BRANCH:         dec_type = TYPE_B;
      OPC_LUI, OPC_AUIPC: dec_type = TYPE_U;
      OPC_JAL:            dec_type = TYPE_J;
      default:            dec_type = TYPE_NONE;
    endcase
  end

  // Immediate construction. Every sign-extended form fits in 32 bits with
  // bit 31 as the sign, so it is built at 32 bits and then widened signed.
  always_comb begin
    imm32 = '0;
    case (dec_type)
      TYPE_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      TYPE_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      TYPE_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
      TYPE_U: imm32 = {i_instr[31:12], 12'b0};
      TYPE_J: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec_imm = XLEN'($signed(imm32));
    if (dec_type == TYPE_SHAMT) begin
      // funct7 never leaks into the shift amount; only RV64 OP-IMM has a
      // 6-bit shamt, the word forms keep 5 bits.
      if ((XLEN == 64) && (opcode == OPC_OP_IMM)) begin
        dec_imm = XLEN'(i_instr[25:20]);
      end else begin
        dec_imm = XLEN'(i_instr[24:20]);
      end
    end
  end

  assign dec_target = i_pc + dec_imm;

  // Pipeline stages
  logic [DEPTH-1:0] valid_q;
  logic [XLEN-1:0]  imm_q  [DEPTH];
  logic [2:0]       type_q [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  tgt_q  [DEPTH];
  logic [DEPTH:0]   stage_ready;
  logic             ready_acc;

  // A stage can load if it or any stage downstream of it has a hole, or the
  // consumer is taking the output. The chain is accumulated from the output
  // side so no bit of stage_ready reads another bit of itself.
  always_comb begin
    ready_acc          = i_ready;
    stage_ready        = '0;
    stage_ready[DEPTH] = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_acc      = ready_acc | ~valid_q[k];
      stage_ready[k] = ready_acc;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        imm_q[k]  <= '0;
        type_q[k] <= '0;
        pc_q[k]   <= '0;
        tgt_q[k]  <= '0;
      end
    end else if (i_flush) begin
      // Payload is left as-is; only the valids matter once flushed.
      valid_q <= '0;
    end else begin
      if (stage_ready[0]) begin
        valid_q[0] <= i_valid;
        if (i_valid) begin
          imm_q[0]  <= dec_imm;
          type_q[0] <= dec_type;
          pc_q[0]   <= i_pc;
          tgt_q[0]  <= dec_target;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            imm_q[k]  <= imm_q[k-1];
            type_q[k] <= type_q[k-1];
            pc_q[k]   <= pc_q[k-1];
            tgt_q[k]  <= tgt_q[k-1];
          end
        end
      end
    end
  end

  assign o_ready    = stage_ready[0];
  assign o_valid    = valid_q[DEPTH-1];
  assign o_imm      = imm_q[DEPTH-1];
  assign o_imm_type = type_q[DEPTH-1];
  assign o_pc       = pc_q[DEPTH-1];
  assign o_target   = tgt_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_immgen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_immgen_pipe
// Description : Directed self-checking bench for immgen_pipe. Three instances:
//               DEPTH=1/XLEN=32, DEPTH=1/XLEN=64 and DEPTH=3/XLEN=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_immgen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DEPTH=1 instances share their stimulus
  logic        v1, r1, fl1;
  logic [31:0] instr1;
  logic [63:0] pc64;
  logic        or1, ov1, or64, ov64;
  logic [31:0] imm1, pco1, tgt1;
  logic [2:0]  ty1, ty64;
  logic [63:0] imm64, pco64, tgt64;

  // DEPTH=3 instance
  logic        v3, r3, fl3, or3, ov3;
  logic [31:0] instr3, pc3, imm3, pco3, tgt3;
  logic [2:0]  ty3;

  int compared   = 0;
  int mismatched = 0;

  immgen_pipe #(.XLEN(32), .DEPTH(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .o_ready(or1), .i_instr(instr1),
    .i_pc(pc64[31:0]), .i_flush(fl1), .o_valid(ov1), .i_ready(r1), .o_imm(imm1),
    .o_imm_type(ty1), .o_pc(pco1), .o_target(tgt1));

  immgen_pipe #(.XLEN(64), .DEPTH(1)) dut64 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .o_ready(or64), .i_instr(instr1),
    .i_pc(pc64), .i_flush(fl1), .o_valid(ov64), .i_ready(r1), .o_imm(imm64),
    .o_imm_type(ty64), .o_pc(pco64), .o_target(tgt64));

  immgen_pipe #(.XLEN(32), .DEPTH(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_valid(v3), .o_ready(or3), .i_instr(instr3),
    .i_pc(pc3), .i_flush(fl3), .o_valid(ov3), .i_ready(r3), .o_imm(imm3),
    .o_imm_type(ty3), .o_pc(pco3), .o_target(tgt3));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  typ;
  } vec_t;

  localparam int NVEC = 13;

  // Hand-decoded XLEN=32 vectors
  function automatic vec_t get_vec(input int i);
    case (i)
      0:  return '{32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, 3'd1}; // addi -1
      1:  return '{32'hFE112E23, 32'h0000_0004, 32'hFFFFFFFC, 3'd2}; // sw -4
      2:  return '{32'h123450B7, 32'h0000_0008, 32'h12345000, 3'd4}; // lui
      3:  return '{32'h41F0D093, 32'h0000_000C, 32'h0000001F, 3'd6}; // srai 31
      4:  return '{32'hFFDFF06F, 32'h0000_0100, 32'hFFFFFFFC, 3'd5}; // jal -4
      5:  return '{32'h0000007F, 32'h0000_0010, 32'h00000000, 3'd0}; // unknown
      6:  return '{32'hFE000CE3, 32'h0000_0200, 32'hFFFFFFF8, 3'd3}; // beq -8
      7:  return '{32'h00001097, 32'h0000_1000, 32'h00001000, 3'd4}; // auipc
      8:  return '{32'h00452083, 32'h0000_0014, 32'h00000004, 3'd1}; // lw 4
      9:  return '{32'h000080E7, 32'h0000_0018, 32'h00000000, 3'd1}; // jalr 0
      10: return '{32'h0010909B, 32'h0000_001C, 32'h00000000, 3'd0}; // slliw on RV32
      11: return '{32'hFFC00093, 32'h0000_0000, 32'hFFFFFFFC, 3'd1}; // wrap target
      default: return '{32'h03F09093, 32'h0000_0020, 32'h0000001F, 3'd6}; // slli, bit25 set
    endcase
  endfunction

  task automatic send1(input logic [31:0] ins, input logic [63:0] pc);
    @(negedge clk);
    instr1 = ins;
    pc64   = pc;
    v1     = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({ov1, imm1, ty1, pco1, tgt1} !== '0) begin
      mismatched++;
      $display("FAIL reset_d1_outputs: got v=%b imm=%h ty=%0d pc=%h tgt=%h, want all 0",
               ov1, imm1, ty1, pco1, tgt1);
    end
    compared++;
    if ({ov3, imm3, ty3, pco3, tgt3} !== '0) begin
      mismatched++;
      $display("FAIL reset_d3_outputs: got v=%b imm=%h ty=%0d pc=%h tgt=%h, want all 0",
               ov3, imm3, ty3, pco3, tgt3);
    end
    @(negedge clk);
    rst = 1'b0;
    r3  = 1'b0;
    #1;
    compared++;
    if (or1 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_d1: got %b want 1", or1);
    end
    compared++;
    if (or3 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_d3: got %b want 1", or3);
    end
    r3 = 1'b1;
  endtask

  task automatic test_decode32();
    vec_t v;
    logic [31:0] exp_tgt;
    for (int i = 0; i < NVEC; i++) begin
      v = get_vec(i);
      exp_tgt = v.pc + v.imm;
      send1(v.instr, {32'h0, v.pc});
      compared++;
      if ({ov1, ty1} !== {1'b1, v.typ}) begin
        mismatched++;
        $display("FAIL decode32_type[%0d]: got v=%b ty=%0d want v=1 ty=%0d", i, ov1, ty1, v.typ);
      end
      compared++;
      if (imm1 !== v.imm) begin
        mismatched++;
        $display("FAIL decode32_imm[%0d]: got %h want %h", i, imm1, v.imm);
      end
      compared++;
      if ({pco1, tgt1} !== {v.pc, exp_tgt}) begin
        mismatched++;
        $display("FAIL decode32_target[%0d]: got pc=%h tgt=%h want pc=%h tgt=%h",
                 i, pco1, tgt1, v.pc, exp_tgt);
      end
    end
  endtask

  task automatic test_decode64();
    logic [31:0] ins [4];
    logic [63:0] pcs [4];
    logic [63:0] imms[4];
    logic [63:0] tgts[4];
    logic [2:0]  tys [4];
    ins[0] = 32'h03F09093; pcs[0] = 64'h0;           imms[0] = 64'h3F;                tys[0] = 3'd6;
    ins[1] = 32'h03F0909B; pcs[1] = 64'h0;           imms[1] = 64'h1F;                tys[1] = 3'd6;
    ins[2] = 32'hFFF0809B; pcs[2] = 64'h10;          imms[2] = 64'hFFFFFFFF_FFFFFFFF; tys[2] = 3'd1;
    ins[3] = 32'h800000B7; pcs[3] = 64'h1_0000_0000; imms[3] = 64'hFFFFFFFF_80000000; tys[3] = 3'd4;
    tgts[0] = 64'h3F; tgts[1] = 64'h1F; tgts[2] = 64'hF; tgts[3] = 64'h80000000;
    for (int i = 0; i < 4; i++) begin
      send1(ins[i], pcs[i]);
      compared++;
      if ({ov64, ty64, imm64, tgts[i]} !== {1'b1, tys[i], imms[i], tgt64}) begin
        mismatched++;
        $display("FAIL decode64[%0d]: got v=%b ty=%0d imm=%h tgt=%h want v=1 ty=%0d imm=%h tgt=%h",
                 i, ov64, ty64, imm64, tgt64, tys[i], imms[i], tgts[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    r3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 6) begin
        v = get_vec(c);
        instr3 = v.instr;
        pc3    = v.pc;
        v3     = 1'b1;
      end else begin
        v3 = 1'b0;
      end
      #1;
      compared++;
      if (or3 !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", c, or3);
      end
      if (c >= 3 && c < 9) begin
        v = get_vec(c - 3);
        compared++;
        if ({ov3, imm3, ty3, pco3} !== {1'b1, v.imm, v.typ, v.pc}) begin
          mismatched++;
          $display("FAIL b2b_out[%0d]: got v=%b imm=%h ty=%0d pc=%h want v=1 imm=%h ty=%0d pc=%h",
                   c, ov3, imm3, ty3, pco3, v.imm, v.typ, v.pc);
        end
      end else begin
        compared++;
        if (ov3 !== 1'b0) begin
          mismatched++;
          $display("FAIL b2b_idle[%0d]: got o_valid=%b want 0", c, ov3);
        end
      end
    end
  endtask

  // Fill the DEPTH=3 pipe with beats 1,2,3 while the consumer is stalled.
  task automatic fill3();
    vec_t v;
    r3 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      v = get_vec(i);
      @(negedge clk);
      instr3 = v.instr;
      pc3    = v.pc;
      v3     = 1'b1;
    end
    @(negedge clk);
    v3 = 1'b0;
    #1;
  endtask

  task automatic test_stall_flush();
    vec_t v;
    fill3();
    v = get_vec(1);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({or3, ov3, imm3, pco3} !== {1'b0, 1'b1, v.imm, v.pc}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b imm=%h pc=%h want rdy=0 v=1 imm=%h pc=%h",
                 i, or3, ov3, imm3, pco3, v.imm, v.pc);
      end
      @(negedge clk);
      #1;
    end
    // Flush with a live input beat in the same cycle
    v = get_vec(4);
    instr3 = v.instr;
    pc3    = v.pc;
    v3     = 1'b1;
    fl3    = 1'b1;
    @(negedge clk);
    fl3 = 1'b0;
    v3  = 1'b0;
    r3  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if (ov3 !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_empty[%0d]: got o_valid=%b want 0", i, ov3);
      end
      @(negedge clk);
    end
    // Post-flush beat: visible after the third edge counting the accept edge
    v = get_vec(6);
    instr3 = v.instr;
    pc3    = v.pc;
    v3     = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin
        compared++;
        if (ov3 !== 1'b0) begin
          mismatched++;
          $display("FAIL post_flush_early[%0d]: got o_valid=%b want 0", i, ov3);
        end
        @(negedge clk);
      end else begin
        compared++;
        if ({ov3, imm3, ty3, tgt3} !== {1'b1, v.imm, v.typ, 32'h1F8}) begin
          mismatched++;
          $display("FAIL post_flush_beat: got v=%b imm=%h ty=%0d tgt=%h want v=1 imm=%h ty=%0d tgt=000001f8",
                   ov3, imm3, ty3, tgt3, v.imm, v.typ);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    fill3();
    r1 = 1'b0;
    send1(32'h123450B7, 64'h40);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({ov3, imm3, ty3, pco3, tgt3} !== '0) begin
      mismatched++;
      $display("FAIL async_reset_d3: got v=%b imm=%h ty=%0d pc=%h tgt=%h want all 0",
               ov3, imm3, ty3, pco3, tgt3);
    end
    compared++;
    if ({ov1, imm1, ty1, pco1, tgt1} !== '0) begin
      mismatched++;
      $display("FAIL async_reset_d1: got v=%b imm=%h ty=%0d pc=%h tgt=%h want all 0",
               ov1, imm1, ty1, pco1, tgt1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if ({or3, ov3} !== 2'b10) begin
      mismatched++;
      $display("FAIL async_reset_release: got rdy=%b v=%b want rdy=1 v=0", or3, ov3);
    end
    r1 = 1'b1;
    r3 = 1'b1;
  endtask

  task automatic test_random_stream();
    vec_t q[$];
    vec_t cur, exp;
    logic [31:0] exp_tgt;
    logic        hold    = 1'b0;
    logic        stalled = 1'b0;
    logic [98:0] saved   = '0;
    int sent = 0, got = 0, cycles = 0;
    cur = '0;
    while (got < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!hold) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          cur    = get_vec($urandom_range(0, NVEC - 1));
          cur.pc = $urandom;
          instr3 = cur.instr;
          pc3    = cur.pc;
          v3     = 1'b1;
        end else begin
          v3 = 1'b0;
        end
      end
      r3 = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        compared++;
        if ({ov3, imm3, ty3, pco3, tgt3} !== {1'b1, saved}) begin
          mismatched++;
          $display("FAIL stream_stable: got v=%b imm=%h ty=%0d pc=%h tgt=%h after stall",
                   ov3, imm3, ty3, pco3, tgt3);
        end
      end
      if (ov3 && r3) begin
        compared++;
        got++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL stream_extra: got beat imm=%h pc=%h want none", imm3, pco3);
        end else begin
          exp     = q.pop_front();
          exp_tgt = exp.pc + exp.imm;
          if ({imm3, ty3, pco3, tgt3} !== {exp.imm, exp.typ, exp.pc, exp_tgt}) begin
            mismatched++;
            $display("FAIL stream_beat[%0d]: got imm=%h ty=%0d pc=%h tgt=%h want imm=%h ty=%0d pc=%h tgt=%h",
                     got, imm3, ty3, pco3, tgt3, exp.imm, exp.typ, exp.pc, exp_tgt);
          end
        end
      end
      if (v3 && or3) begin
        q.push_back(cur);
        sent++;
        hold = 1'b0;
      end else begin
        hold = v3;
      end
      stalled = ov3 && !r3;
      saved   = {imm3, ty3, pco3, tgt3};
    end
    v3 = 1'b0;
    r3 = 1'b1;
    compared++;
    if (got != 1000 || q.size() != 0) begin
      mismatched++;
      $display("FAIL stream_count: got %0d beats, %0d left queued; want 1000 and 0",
               got, q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; r1 = 1'b1; fl1 = 1'b0; instr1 = '0; pc64 = '0;
    v3 = 1'b0; r3 = 1'b1; fl3 = 1'b0; instr3 = '0; pc3  = '0;
    test_reset();
    test_decode32();
    test_decode64();
    test_back_to_back();
    test_stall_flush();
    test_async_reset();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
